bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h6000, 8-byte-aligned base of the register window.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  16  CPU bus address.
REQ-005 SHALL have port data_in  input  8  CPU write data.
REQ-006 SHALL have port wrt_en  input  1  1 = CPU write cycle, 0 = read cycle.
REQ-007 SHALL have port data_out  output  8  read data for the bus mux.
REQ-008 SHALL have port selected  output  1  high when address[15:3] == BASE_ADDR[15:3].
REQ-009 SHALL have port irq_n  output  1  active-low interrupt request.

Function
REQ-010 Register map by address[2:0]: 0 CTRL (bit0 EN, bit1 AUTO, bit2 IRQEN, bits7:3 read 0); 1 STATUS (bit0 EXP); 2 LATCH_LO; 3 LATCH_HI; 4 COUNT_LO; 5 COUNT_HI; 6 PRESCALE; 7 reserved.
REQ-011 Write SHALL occur on the rising edge when selected && wrt_en; writes to COUNT_LO, COUNT_HI and reserved are ignored.
REQ-012 data_out SHALL be combinational: register value when selected && !wrt_en, else 8'h00; reserved reads 8'h00.
REQ-013 Reading COUNT_LO (selected, !wrt_en, offset 4, at a rising edge) SHALL capture count[15:8] into a holding register; COUNT_HI reads return the holding register.
REQ-014 STATUS write SHALL clear EXP for each data_in bit written as 1 (write-1-to-clear); 0 bits have no effect.
REQ-015 State machine SHALL have two states, STOPPED and RUNNING.
REQ-016 STOPPED -> RUNNING on a CTRL write with EN=1 while EN was 0: count <= {LATCH_HI,LATCH_LO}, pcnt <= PRESCALE.
REQ-017 A CTRL write with EN=1 while RUNNING SHALL update AUTO/IRQEN only; no reload/restart.
REQ-018 RUNNING, each edge: if pcnt != 0, pcnt decrements; else tick: pcnt <= PRESCALE and count decrements if nonzero.
REQ-019 A tick with count == 0 SHALL set EXP; if AUTO=1, count <= latch and stay RUNNING; else clear EN, go STOPPED, count holds 0.
REQ-020 First expiry SHALL occur exactly (L+1)*(P+1) edges after the enabling write edge; auto-reload period SHALL be (L+1)*(P+1) clocks.
REQ-021 L=0 or P=0 SHALL be legal; L=0,P=0 expires on every edge with AUTO=1.
REQ-022 CTRL write with EN=0 while RUNNING SHALL go STOPPED; count and pcnt hold their values.
REQ-023 LATCH/PRESCALE writes while RUNNING SHALL take effect only at the next reload (REQ-016/018/019).
REQ-024 Expiry and STATUS clear on the same edge: set SHALL win, EXP = 1.
REQ-025 Expiry and CTRL EN=0 write on the same edge: EXP SHALL set and state SHALL be STOPPED.
REQ-026 irq_n SHALL equal !(EXP && IRQEN), driven from registers (no combinational path from bus inputs).
REQ-027 count arithmetic SHALL be 16-bit unsigned and never wrap below 0.

Reset
REQ-028 reset low SHALL immediately force: CTRL, STATUS, latch, PRESCALE, count, pcnt and holding register to 0; state STOPPED.
REQ-029 In reset, irq_n = 1; data_out follows REQ-012 with all-zero registers.
REQ-030 Reset asserted mid-count SHALL abort the run; after release the block stays STOPPED until a new EN write.

Verification
REQ-031 Write LATCH=0x0003, PRESCALE=0, CTRL=0x05 at edge E -> EXP=1, irq_n=0 at edge E+4; STOPPED; CTRL reads 0x04.
REQ-032 LATCH=0x0001, PRESCALE=2, CTRL=0x03 -> EXP sets at E+6, E+12, E+18; STATUS write 0x01 clears EXP between expiries.
REQ-033 Running count 0x1234: read COUNT_LO, then COUNT_HI 3 edges later after decrements -> HI returns 0x12 captured at the LO read.
REQ-034 STATUS write 0x01 on the expiry edge -> EXP reads 1 afterwards.
REQ-035 address = BASE_ADDR+8 with write -> no register changes, selected=0, data_out=0x00.
REQ-036 reset pulled low mid-run with irq_n=0 -> irq_n=1 and all registers read 0x00 without a clock edge.

Source files
------------

// File: rtl/bus_timer.sv
// Bus-mapped 16-bit down-counting timer with 8-bit prescaler, auto-reload and
// active-low interrupt, exposed through an eight-byte register window.
//
// state   | meaning
// STOPPED | counter idle; count/pcnt hold, CTRL.EN reads 0
// RUNNING | prescaler and counter advancing; CTRL.EN reads 1
module bus_timer #(
  parameter logic [15:0] BASE_ADDR = 16'h6000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  input  logic        wrt_en,
  output logic [7:0]  data_out,
  output logic        selected,
  output logic        irq_n
);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_STATUS   = 3'd1;
  localparam logic [2:0] OFF_LATCH_LO = 3'd2;
  localparam logic [2:0] OFF_LATCH_HI = 3'd3;
  localparam logic [2:0] OFF_COUNT_LO = 3'd4;
  localparam logic [2:0] OFF_COUNT_HI = 3'd5;
  localparam logic [2:0] OFF_PRESCALE = 3'd6;

  state_t      state, state_nxt;
  logic        auto_q, auto_nxt;
  logic        irqen_q, irqen_nxt;
  logic        exp_q, exp_nxt;
  logic [15:0] latch_q, latch_nxt;
  logic [15:0] count_q, count_nxt;
  logic [7:0]  pre_q, pre_nxt;
  logic [7:0]  pcnt_q, pcnt_nxt;
  logic [7:0]  hold_q, hold_nxt;

  logic [2:0]  off;
  logic        bus_wr;
  logic        bus_rd;
  logic        ctrl_wr;

  assign selected = (address[15:3] == BASE_ADDR[15:3]);
  assign off      = address[2:0];
  assign bus_wr   = selected & wrt_en;
  assign bus_rd   = selected & ~wrt_en;
  assign ctrl_wr  = bus_wr && (off == OFF_CTRL);

  // Interrupt depends only on flops, never on the bus inputs.
  assign irq_n = ~(exp_q & irqen_q);

  always_comb begin
    data_out = 8'h00;
    if (bus_rd) begin
      case (off)
        OFF_CTRL:     data_out = {5'b0, irqen_q, auto_q, (state == RUNNING)};
        OFF_STATUS:   data_out = {7'b0, exp_q};
        OFF_LATCH_LO: data_out = latch_q[7:0];
        OFF_LATCH_HI: data_out = latch_q[15:8];
        OFF_COUNT_LO: data_out = count_q[7:0];
        OFF_COUNT_HI: data_out = hold_q;
        OFF_PRESCALE: data_out = pre_q;
        default:      data_out = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    auto_nxt  = auto_q;
    irqen_nxt = irqen_q;
    exp_nxt   = exp_q;
    latch_nxt = latch_q;
    count_nxt = count_q;
    pre_nxt   = pre_q;
    pcnt_nxt  = pcnt_q;
    hold_nxt  = hold_q;

    if (bus_rd && (off == OFF_COUNT_LO)) begin
      hold_nxt = count_q[15:8];
    end

    if (bus_wr) begin
      case (off)
        OFF_CTRL: begin
          auto_nxt  = data_in[1];
          irqen_nxt = data_in[2];
        end
        OFF_STATUS:   exp_nxt = exp_q & ~data_in[0];
        OFF_LATCH_LO: latch_nxt[7:0] = data_in;
        OFF_LATCH_HI: latch_nxt[15:8] = data_in;
        OFF_PRESCALE: pre_nxt = data_in;
        default: ;
      endcase
    end

    // Timer evaluated after the bus so an expiry overrides a same-edge W1C.
    case (state)
      STOPPED: begin
        if (ctrl_wr && data_in[0]) begin
          state_nxt = RUNNING;
          count_nxt = latch_q;
          pcnt_nxt  = pre_q;
        end
      end
      RUNNING: begin
        if (pcnt_q != 8'd0) begin
          pcnt_nxt = pcnt_q - 8'd1;
        end else begin
          pcnt_nxt = pre_q;
          if (count_q != 16'd0) begin
            count_nxt = count_q - 16'd1;
          end else begin
            exp_nxt = 1'b1;
            if (auto_q) begin
              count_nxt = latch_q;
            end else begin
              state_nxt = STOPPED;
            end
          end
        end
        if (ctrl_wr && !data_in[0]) begin
          state_nxt = STOPPED;
          count_nxt = count_q;
          pcnt_nxt  = pcnt_q;
        end
      end
      default: state_nxt = STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= STOPPED;
      auto_q  <= 1'b0;
      irqen_q <= 1'b0;
      exp_q   <= 1'b0;
      latch_q <= 16'd0;
      count_q <= 16'd0;
      pre_q   <= 8'd0;
      pcnt_q  <= 8'd0;
      hold_q  <= 8'd0;
    end else begin
      state   <= state_nxt;
      auto_q  <= auto_nxt;
      irqen_q <= irqen_nxt;
      exp_q   <= exp_nxt;
      latch_q <= latch_nxt;
      count_q <= count_nxt;
      pre_q   <= pre_nxt;
      pcnt_q  <= pcnt_nxt;
      hold_q  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed scenarios plus random bus traffic, all checked
// against an elapsed-edge arithmetic model of the timer.
module tb_bus_timer;

  localparam logic [15:0] BASE = 16'h6000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        wrt_en;
  logic [7:0]  data_out;
  logic        selected;
  logic        irq_n;

  always #5 clk = ~clk;

  bus_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .wrt_en(wrt_en), .data_out(data_out), .selected(selected), .irq_n(irq_n)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: while running, count is derived from edges elapsed since the last load.
  bit          m_run, m_auto, m_irqen, m_exp;
  int          m_e, m_L, m_P;
  logic [15:0] m_latch, m_frozen;
  logic [7:0]  m_pre, m_hold;

  logic [7:0]  last_rd;
  logic        last_sel, last_irq;

  task automatic model_reset();
    m_run = 0; m_auto = 0; m_irqen = 0; m_exp = 0;
    m_e = 0; m_L = 0; m_P = 0;
    m_latch = '0; m_frozen = '0; m_pre = '0; m_hold = '0;
  endtask

  function automatic logic [15:0] m_count();
    if (!m_run) return m_frozen;
    return 16'(m_L - (m_e / (m_P + 1)) % (m_L + 1));
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a, input bit w);
    logic [15:0] c;
    c = m_count();
    if (a[15:3] != BASE[15:3] || w) return 8'h00;
    case (a[2:0])
      3'd0: return {5'b0, m_irqen, m_auto, m_run};
      3'd1: return {7'b0, m_exp};
      3'd2: return m_latch[7:0];
      3'd3: return m_latch[15:8];
      3'd4: return c[7:0];
      3'd5: return m_hold;
      3'd6: return m_pre;
      default: return 8'h00;
    endcase
  endfunction

  task automatic bus_cycle(input logic [15:0] a, input bit w, input logic [7:0] d);
    bit sel, is_exp, old_auto, was_run;
    logic [15:0] cur, old_latch;
    logic [7:0] old_pre;
    @(negedge clk);
    address = a; wrt_en = w; data_in = d;
    #1;
    sel = (a[15:3] == BASE[15:3]);
    last_rd = data_out; last_sel = selected; last_irq = irq_n;
    check("data_out", data_out, m_read(a, w));
    check("selected", selected, sel);
    check("irq_n", irq_n, !(m_exp && m_irqen));
    @(posedge clk);
    cur = m_count();
    is_exp = m_run && (((m_e + 1) % ((m_L + 1) * (m_P + 1))) == 0);
    old_latch = m_latch; old_pre = m_pre; old_auto = m_auto; was_run = m_run;
    if (sel && !w && a[2:0] == 3'd4) m_hold = cur[15:8];
    if (sel && w) begin
      case (a[2:0])
        3'd0: begin m_auto = d[1]; m_irqen = d[2]; end
        3'd1: if (d[0]) m_exp = 0;
        3'd2: m_latch[7:0] = d;
        3'd3: m_latch[15:8] = d;
        3'd6: m_pre = d;
        default: ;
      endcase
    end
    if (was_run) begin
      if (is_exp) m_exp = 1;
      if (sel && w && a[2:0] == 3'd0 && !d[0]) begin m_run = 0; m_frozen = cur; end
      else if (is_exp && !old_auto) begin m_run = 0; m_frozen = 16'd0; end
      else if (is_exp) begin m_L = old_latch; m_P = old_pre; m_e = 0; end
      else m_e++;
    end else if (sel && w && a[2:0] == 3'd0 && d[0]) begin
      m_run = 1; m_e = 0; m_L = old_latch; m_P = old_pre;
    end
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    bus_cycle(BASE + 16'(off), 1'b1, d);
  endtask

  task automatic rdc(input int off);
    bus_cycle(BASE + 16'(off), 1'b0, 8'h00);
  endtask

  // Asserts reset between edges and checks the outputs immediately.
  task automatic do_reset();
    @(negedge clk);
    address = BASE + 16'd1; wrt_en = 1'b0; data_in = 8'h00;
    reset = 1'b0;
    #1;
    check("rst_irq_n", irq_n, 1'b1);
    check("rst_status", data_out, 8'h00);
    for (int i = 0; i < 8; i++) begin
      address = BASE + 16'(i);
      #0.5;
      check("rst_reg", data_out, 8'h00);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int r, e;
    logic [15:0] a;
    reset = 1'b0; address = '0; wrt_en = 1'b0; data_in = '0;
    model_reset();
    do_reset();

    // One-shot with IRQ: L=3, P=0 expires four edges after enable.
    wr(2, 8'h03); wr(3, 8'h00); wr(6, 8'h00); wr(0, 8'h05);
    for (int k = 1; k <= 4; k++) begin
      rdc(1); check("oneshot_pre", last_rd, 8'h00);
    end
    rdc(1); check("oneshot_exp", last_rd, 8'h01);
    check("oneshot_irq", last_irq, 1'b0);
    rdc(0); check("oneshot_ctrl", last_rd, 8'h04);

    // Auto-reload L=1, P=2: expiries at E+6, E+12, E+18 with W1C between.
    do_reset();
    wr(2, 8'h01); wr(3, 8'h00); wr(6, 8'h02); wr(0, 8'h03);
    for (int k = 1; k <= 19; k++) begin
      if (k == 9 || k == 15) wr(1, 8'h01);
      else begin
        rdc(1);
        e = k - 1;
        check("auto_exp", last_rd,
              ((e >= 6 && e < 9) || (e >= 12 && e < 15) || e >= 18) ? 8'h01 : 8'h00);
      end
    end
    wr(0, 8'h00);

    // COUNT_HI returns the byte captured by the earlier COUNT_LO read.
    do_reset();
    wr(2, 8'h02); wr(3, 8'h12); wr(6, 8'h00); wr(0, 8'h01);
    rdc(4); check("cnt_lo", last_rd, 8'h02);
    rdc(0); rdc(0);
    rdc(5); check("cnt_hi_held", last_rd, 8'h12);
    rdc(4); check("cnt_lo2", last_rd, 8'hFE);
    rdc(5); check("cnt_hi2", last_rd, 8'h11);
    wr(0, 8'h00);

    // STATUS clear on the expiry edge: set wins.
    do_reset();
    wr(2, 8'h02); wr(3, 8'h00); wr(6, 8'h00); wr(0, 8'h01);
    rdc(1); rdc(1); wr(1, 8'h01);
    rdc(1); check("set_wins", last_rd, 8'h01);
    rdc(0); check("set_wins_ctrl", last_rd, 8'h00);

    // Expiry and EN=0 write on the same edge.
    do_reset();
    wr(2, 8'h01); wr(3, 8'h00); wr(6, 8'h00); wr(0, 8'h03);
    rdc(1); check("stop_pre", last_rd, 8'h00);
    wr(0, 8'h02);
    rdc(1); check("stop_exp", last_rd, 8'h01);
    rdc(0); check("stop_ctrl", last_rd, 8'h02);
    rdc(4); check("stop_cnt", last_rd, 8'h00);

    // Access just above the window.
    bus_cycle(BASE + 16'd8, 1'b1, 8'hFF);
    check("oow_sel", last_sel, 1'b0); check("oow_rd", last_rd, 8'h00);
    bus_cycle(BASE + 16'd10, 1'b0, 8'h00);
    check("oow_rd2", last_rd, 8'h00);
    for (int i = 0; i < 8; i++) rdc(i);

    // Reset mid-run while interrupting, then stays stopped.
    do_reset();
    wr(2, 8'h00); wr(3, 8'h00); wr(6, 8'h00); wr(0, 8'h07);
    rdc(1); rdc(1); rdc(1);
    check("l0p0_irq", last_irq, 1'b0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rdc(0); check("post_rst_ctrl", last_rd, 8'h00);
    end

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        a = BASE ^ (16'h0008 << $urandom_range(0, 12));
        a[2:0] = 3'($urandom);
        bus_cycle(a, 1'($urandom), 8'($urandom));
      end
      else if (r < 60) rdc($urandom_range(0, 7));
      else if (r < 70) wr(1, 8'($urandom));
      else if (r < 77) wr(0, 8'($urandom));
      else if (r < 84) wr(2, 8'($urandom_range(0, 15)));
      else if (r < 88) wr(3, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
      else if (r < 93) begin
        if (!m_run) wr(6, 8'($urandom_range(0, 3)));
        else rdc(4);
      end
      else begin
        r = $urandom_range(0, 2);
        wr((r == 2) ? 7 : 4 + r, 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
